// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: request-kind codes, opcode/funct constants and FSM states
// shared by the instruction encoder and its word packer.
package instr_encoder_pkg;

    localparam logic [1:0] KIND_R    = 2'd0;
    localparam logic [1:0] KIND_I    = 2'd1;
    localparam logic [1:0] KIND_J    = 2'd2;
    localparam logic [1:0] KIND_LI32 = 2'd3;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] FN_SLL     = 6'h00;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] LI_SHAMT = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_LI_HI,
        S_LI_SLL,
        S_LI_LO
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational packing of registered request fields into the
// 32-bit word for the current encoder state; zero while idle.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  state,
    input  logic [1:0]  kind,
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    input  logic [25:0] addr26,
    output logic [31:0] word
);

    logic [31:0] r_word, i_word, j_word, emit_word;
    logic [31:0] hi_word, sll_word, lo_word;

    assign r_word   = {OP_SPECIAL, rs, rt, rd, shamt, op};
    assign i_word   = {op, rs, rt, imm[15:0]};
    assign j_word   = {op, addr26};
    // LI32 expands to addi / sll 16 / ori on the same destination register
    assign hi_word  = {OP_ADDI, REG_ZERO, rt, imm[31:16]};
    assign sll_word = {OP_SPECIAL, REG_ZERO, rt, rt, LI_SHAMT, FN_SLL};
    assign lo_word  = {OP_ORI, rt, rt, imm[15:0]};

    always_comb begin
        emit_word = (kind == KIND_R) ? r_word : (kind == KIND_I) ? i_word : j_word;
        word = (state == S_EMIT)   ? emit_word :
               (state == S_LI_HI)  ? hi_word   :
               (state == S_LI_SLL) ? sll_word  :
               (state == S_LI_LO)  ? lo_word   : 32'h0;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts R/I/J/LI32 requests and streams encoded words to
// instruction memory at an auto-incrementing, wrapping word address.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_imm,
    input  logic [25:0]       in_addr26,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              wrapped
);

    state_e            state_q, state_d;
    logic [1:0]        kind_q;
    logic [5:0]        op_q;
    logic [4:0]        rs_q, rt_q, rd_q, shamt_q;
    logic [31:0]       imm_q;
    logic [25:0]       addr26_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wrapped_q;
    logic              in_fire, wr_fire;

    assign in_ready = (state_q == S_IDLE);
    assign wr_valid = (state_q != S_IDLE);
    assign in_fire  = in_valid && in_ready;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_addr  = addr_q;
    assign wrapped  = wrapped_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_fire) state_d = (in_kind == KIND_LI32) ? S_LI_HI : S_EMIT;
            S_EMIT:   if (wr_ready) state_d = S_IDLE;
            S_LI_HI:  if (wr_ready) state_d = S_LI_SLL;
            S_LI_SLL: if (wr_ready) state_d = S_LI_LO;
            S_LI_LO:  if (wr_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_fire) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (&addr_q) wrapped_q <= 1'b1;
            end
        end
    end

    // Fields are captured only on transfer so a pending sequence ignores the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q   <= '0;
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            shamt_q  <= '0;
            imm_q    <= '0;
            addr26_q <= '0;
        end else if (in_fire) begin
            kind_q   <= in_kind;
            op_q     <= in_op;
            rs_q     <= in_rs;
            rt_q     <= in_rt;
            rd_q     <= in_rd;
            shamt_q  <= in_shamt;
            imm_q    <= in_imm;
            addr26_q <= in_addr26;
        end
    end

    instr_pack u_pack (
        .state  (state_q),
        .kind   (kind_q),
        .op     (op_q),
        .rs     (rs_q),
        .rt     (rt_q),
        .rd     (rd_q),
        .shamt  (shamt_q),
        .imm    (imm_q),
        .addr26 (addr26_q),
        .word   (wr_data)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors against a default-width encoder and a
// 2-bit-address twin driven by the same stimulus for the wrap behaviour.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_kind = '0;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [31:0] in_imm = '0;
    logic [25:0] in_addr26 = '0;
    logic        wr_ready = 1'b0;
    logic        in_ready, wr_valid, wrapped;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        w2_in_ready, w2_wr_valid, w2_wrapped;
    logic [1:0]  w2_addr;
    logic [31:0] w2_data;

    int n_checks = 0;
    int n_fail = 0;
    int exp_addr = 0;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_addr26(in_addr26),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wrapped(wrapped)
    );

    instr_encoder #(.ADDR_W(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w2_in_ready),
        .in_kind(in_kind), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_addr26(in_addr26),
        .wr_valid(w2_wr_valid), .wr_ready(wr_ready), .wr_addr(w2_addr),
        .wr_data(w2_data), .wrapped(w2_wrapped)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] kind, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] shamt,
                        input logic [31:0] imm, input logic [25:0] a26);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_kind = kind; in_op = op; in_rs = rs; in_rt = rt;
        in_rd = rd; in_shamt = shamt; in_imm = imm; in_addr26 = a26;
        @(negedge clk);
        // scramble the bus: the pending words must come from captured fields
        in_valid = 1'b0; in_kind = ~kind; in_op = ~op; in_rs = ~rs; in_rt = ~rt;
        in_rd = ~rd; in_shamt = ~shamt; in_imm = ~imm; in_addr26 = ~a26;
    endtask

    task automatic take(input string tag, input logic [31:0] d, input int stall);
        check({tag, "/valid"}, 32'(wr_valid), 32'd1);
        check({tag, "/data"}, wr_data, d);
        check({tag, "/addr"}, 32'(wr_addr), 32'(exp_addr & 1023));
        check({tag, "/w2_data"}, w2_data, d);
        check({tag, "/w2_addr"}, 32'(w2_addr), 32'(exp_addr & 3));
        check({tag, "/wrapped"}, 32'(wrapped), 32'd0);
        check({tag, "/w2_wrapped"}, 32'(w2_wrapped), 32'(exp_addr >= 4));
        check({tag, "/in_ready"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "/stall_valid"}, 32'(wr_valid), 32'd1);
            check({tag, "/stall_data"}, wr_data, d);
            check({tag, "/stall_addr"}, 32'(wr_addr), 32'(exp_addr & 1023));
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        exp_addr++;
    endtask

    task automatic done(input string tag);
        check({tag, "/done_ready"}, 32'(in_ready), 32'd1);
        check({tag, "/done_valid"}, 32'(wr_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst/valid", 32'(wr_valid), 32'd0);
        check("rst/addr", 32'(wr_addr), 32'd0);
        check("rst/data", wr_data, 32'd0);
        check("rst/wrapped", 32'(wrapped), 32'd0);
        check("rst/w2_wrapped", 32'(w2_wrapped), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = 0;
        check("rst/in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        do_reset();

        send(2'd1, 6'h08, 5'd0, 5'd16, 5'd0, 5'd0, 32'h0000FEFE, 26'h0);
        take("addi", 32'h2010FEFE, 0);
        done("addi");

        do_reset();
        send(2'd0, 6'h00, 5'd0, 5'd16, 5'd16, 5'd16, 32'h0, 26'h0);
        take("sll", 32'h00108400, 0);
        done("sll");
        send(2'd0, 6'h20, 5'd0, 5'd0, 5'd8, 5'd0, 32'h0, 26'h0);
        take("add", 32'h00004020, 0);
        done("add");

        send(2'd3, 6'h00, 5'd0, 5'd16, 5'd0, 5'd0, 32'h12345678, 26'h0);
        take("li_hi", 32'h20101234, 0);
        take("li_sll", 32'h00108400, 5);
        take("li_lo", 32'h36105678, 0);
        done("li");

        send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h3ABCDEF);
        take("j", 32'h0BABCDEF, 0);
        done("j");
        send(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, 26'h0);
        take("addu", 32'h00221821, 0);
        send(2'd1, 6'h0D, 5'd3, 5'd4, 5'd0, 5'd0, 32'hAAAA1234, 26'h0);
        take("ori", 32'h34641234, 0);

        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        wr_ready = 1'b0;
        check("idle_ready/addr", 32'(wr_addr), 32'(exp_addr));
        check("idle_ready/valid", 32'(wr_valid), 32'd0);

        send(2'd3, 6'h00, 5'd0, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 26'h0);
        take("abort_hi", 32'h2005DEAD, 0);
        check("abort/mid_valid", 32'(wr_valid), 32'd1);
        check("abort/mid_data", wr_data, 32'h00050000 | 32'h2800 | 32'h400);
        do_reset();
        send(2'd1, 6'h08, 5'd0, 5'd9, 5'd0, 5'd0, 32'h00000001, 26'h0);
        take("post_rst", 32'h20090001, 0);
        done("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
